// File: rtl/game_flow_ctrl.sv
// Screen and gameplay flow controller: title menu, three stages with
// key/light/door objectives, lives with hit invulnerability, result screens.
module game_flow_ctrl #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int START_HEART = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       ev_key,
    input  logic       ev_light,
    input  logic       ev_door,
    input  logic       ev_hit,
    output logic [3:0] state,
    output logic [1:0] key_find,
    output logic [1:0] heart,
    output logic [1:0] todo,
    output logic [3:0] play_valid,
    output logic [1:0] cursor,
    output logic       busy
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] ONE = TW'(1);
    localparam logic [1:0] HEART0 = 2'(START_HEART);

    typedef enum logic [3:0] {
        S_TITLE    = 4'd0,
        S_STAFF    = 4'd1,
        S_STAGE1   = 4'd2,
        S_SUCCESS1 = 4'd3,
        S_STAGE2   = 4'd4,
        S_SUCCESS2 = 4'd5,
        S_STAGE3   = 4'd6,
        S_SUCCESS3 = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        T_NONE  = 2'd0,
        T_KEY   = 2'd1,
        T_LIGHT = 2'd2,
        T_DOOR  = 2'd3
    } todo_t;

    state_t        r_state;
    logic [1:0]    r_cursor;
    logic [1:0]    r_key;
    logic [1:0]    r_heart;
    todo_t         r_todo;
    logic          r_pv2;
    logic          r_pv3;
    logic          r_busy;
    logic          r_entry;
    logic [TW-1:0] r_lock;
    logic [TW-1:0] r_hit;
    logic [1:0]    r_stage;

    state_t     w_next;
    logic [1:0] w_cursor;
    logic [3:0] w_pv;
    logic       w_btn_ok;
    logic       w_up;
    logic       w_down;
    logic       w_sel;
    logic       w_in_stage;
    logic       w_door_acc;
    logic       w_hit_acc;
    logic       w_key_acc;
    logic       w_light_acc;
    logic       w_change;
    logic       w_enter_stage;
    state_t     w_retry;
    state_t     w_pick;
    todo_t      w_first_todo;
    logic [1:0] w_next_stage;

    always_comb begin
        w_pv     = {r_pv3, r_pv2, 2'b10};
        w_btn_ok = !r_busy && !r_entry;
        w_up     = btn_up && w_btn_ok;
        w_down   = btn_down && w_btn_ok;
        w_sel    = btn_sel && w_btn_ok;

        w_in_stage = (r_state == S_STAGE1) || (r_state == S_STAGE2) ||
                     (r_state == S_STAGE3);

        // an accepted door completes the stage and masks a same-cycle hit
        w_door_acc  = w_in_stage && ev_door && (r_todo == T_DOOR);
        w_hit_acc   = w_in_stage && ev_hit && (r_hit == '0) &&
                      (r_heart != 2'd0) && !w_door_acc;
        w_key_acc   = w_in_stage && ev_key && (r_todo == T_KEY) &&
                      (r_key != 2'd3);
        w_light_acc = w_in_stage && ev_light && (r_todo == T_LIGHT);
    end

    always_comb begin
        w_retry = S_STAGE1;
        unique case (r_stage)
            2'd2:    w_retry = S_STAGE2;
            2'd3:    w_retry = S_STAGE3;
            default: w_retry = S_STAGE1;
        endcase
        w_pick = S_STAGE1;
        unique case (r_cursor)
            2'd1:    w_pick = S_STAGE2;
            2'd2:    w_pick = S_STAGE3;
            default: w_pick = S_STAGE1;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_cursor = r_cursor;
        unique case (r_state)
            S_TITLE: begin
                if (w_sel)
                    w_next = w_pick;
                else if (w_down && (r_cursor < 2'd2) && w_pv[r_cursor + 2'd2])
                    w_cursor = r_cursor + 2'd1;
                else if (w_up && (r_cursor != 2'd0))
                    w_cursor = r_cursor - 2'd1;
            end
            S_STAGE1, S_STAGE2, S_STAGE3: begin
                if (w_door_acc)
                    w_next = state_t'(r_state + 4'd1);
                else if (w_hit_acc && (r_heart == 2'd1))
                    w_next = S_FAIL;
            end
            S_SUCCESS1, S_SUCCESS2, S_FAIL: begin
                if (w_sel) begin
                    if (r_cursor != 2'd0)
                        w_next = S_TITLE;
                    else if (r_state == S_FAIL)
                        w_next = w_retry;
                    else
                        w_next = state_t'(r_state + 4'd1);
                end else if (w_down) begin
                    w_cursor = 2'd1;
                end else if (w_up) begin
                    w_cursor = 2'd0;
                end
            end
            S_SUCCESS3: begin
                if (w_sel)
                    w_next = S_STAFF;
            end
            S_STAFF: begin
                if (w_sel)
                    w_next = S_TITLE;
            end
            default: w_next = S_TITLE;
        endcase
    end

    always_comb begin
        w_change      = (w_next != r_state);
        w_enter_stage = (w_next == S_STAGE1) || (w_next == S_STAGE2) ||
                        (w_next == S_STAGE3);
        w_first_todo  = (w_next == S_STAGE2) ? T_LIGHT : T_KEY;
        w_next_stage  = 2'd1;
        unique case (w_next)
            S_STAGE2: w_next_stage = 2'd2;
            S_STAGE3: w_next_stage = 2'd3;
            default:  w_next_stage = 2'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_TITLE;
            r_cursor <= 2'd0;
            r_key    <= 2'd0;
            r_heart  <= 2'd0;
            r_todo   <= T_NONE;
            r_pv2    <= 1'b0;
            r_pv3    <= 1'b0;
            r_busy   <= 1'b0;
            r_entry  <= 1'b0;
            r_lock   <= '0;
            r_hit    <= '0;
            r_stage  <= 2'd1;
        end else begin
            r_state <= w_next;
            r_entry <= w_change;

            if (w_change) begin
                r_cursor <= 2'd0;
                r_lock   <= LOAD;
                r_busy   <= 1'b1;
            end else begin
                r_cursor <= w_cursor;
                r_lock   <= (r_lock != '0) ? r_lock - ONE : '0;
                r_busy   <= (r_lock != '0);
            end

            if (w_change && w_enter_stage)
                r_hit <= '0;
            else if (w_hit_acc)
                r_hit <= LOAD;
            else if (r_hit != '0)
                r_hit <= r_hit - ONE;

            if (w_change && w_enter_stage) begin
                r_key   <= 2'd0;
                r_heart <= HEART0;
                r_todo  <= w_first_todo;
                r_stage <= w_next_stage;
            end else begin
                if (w_key_acc)
                    r_key <= r_key + 2'd1;
                if (w_hit_acc)
                    r_heart <= r_heart - 2'd1;
                if (w_change)
                    r_todo <= T_NONE;
                else if (w_key_acc && (r_key == 2'd2))
                    r_todo <= T_DOOR;
                else if (w_light_acc)
                    r_todo <= T_KEY;
            end

            if (w_door_acc && (r_state == S_STAGE1))
                r_pv2 <= 1'b1;
            if (w_door_acc && (r_state == S_STAGE2))
                r_pv3 <= 1'b1;
        end
    end

    assign state      = r_state;
    assign key_find   = r_key;
    assign heart      = r_heart;
    assign todo       = r_todo;
    assign play_valid = w_pv;
    assign cursor     = r_cursor;
    assign busy       = r_busy;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a per-cycle reference model
// and pinned literal expectations.
module tb_game_flow_ctrl;

    localparam int HOLD = 4;
    localparam int START = 3;

    localparam logic [6:0] B_UP    = 7'b1000000;
    localparam logic [6:0] B_DN    = 7'b0100000;
    localparam logic [6:0] B_SEL   = 7'b0010000;
    localparam logic [6:0] E_KEY   = 7'b0001000;
    localparam logic [6:0] E_LIGHT = 7'b0000100;
    localparam logic [6:0] E_DOOR  = 7'b0000010;
    localparam logic [6:0] E_HIT   = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_sel = 1'b0;
    logic       ev_key = 1'b0;
    logic       ev_light = 1'b0;
    logic       ev_door = 1'b0;
    logic       ev_hit = 1'b0;
    logic [3:0] state;
    logic [1:0] key_find;
    logic [1:0] heart;
    logic [1:0] todo;
    logic [3:0] play_valid;
    logic [1:0] cursor;
    logic       busy;

    int n_pass = 0;
    int n_tot = 0;

    game_flow_ctrl #(.HOLD_CYCLES(HOLD), .START_HEART(START)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .ev_key(ev_key), .ev_light(ev_light), .ev_door(ev_door),
        .ev_hit(ev_hit),
        .state(state), .key_find(key_find), .heart(heart), .todo(todo),
        .play_valid(play_valid), .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int scr;
        int cur;
        int keys;
        int heart;
        int todo;
        bit u2;
        bit u3;
        int age;
        int hage;
        int stg;
    } model_t;

    model_t m;

    function automatic model_t mreset();
        model_t r;
        r.scr = 0; r.cur = 0; r.keys = 0; r.heart = 0; r.todo = 0;
        r.u2 = 0; r.u3 = 0; r.age = HOLD; r.hage = HOLD; r.stg = 1;
        return r;
    endfunction

    function automatic bit is_stage(int s);
        return (s == 2) || (s == 4) || (s == 6);
    endfunction

    function automatic model_t step(model_t o, logic [6:0] v);
        model_t n;
        int nxt;
        bit ok, up, dn, sel, key, lt, door, hit;
        n = o;
        ok = (o.age >= HOLD);
        up = v[6] && ok;
        dn = v[5] && ok;
        sel = v[4] && ok;
        key = v[3]; lt = v[2]; door = v[1]; hit = v[0];
        nxt = o.scr;
        n.hage = (o.hage >= HOLD) ? HOLD : o.hage + 1;
        if (is_stage(o.scr)) begin
            if (door && o.todo == 3) begin
                nxt = o.scr + 1;
                if (o.scr == 2) n.u2 = 1;
                if (o.scr == 4) n.u3 = 1;
            end else begin
                if (lt && o.todo == 2) n.todo = 1;
                if (key && o.todo == 1 && o.keys < 3) begin
                    n.keys = o.keys + 1;
                    if (n.keys == 3) n.todo = 3;
                end
                if (hit && n.hage >= HOLD && o.heart > 0) begin
                    n.heart = o.heart - 1;
                    n.hage = 0;
                    if (n.heart == 0) nxt = 8;
                end
            end
        end else if (o.scr == 0) begin
            if (sel) nxt = 2 * (o.cur + 1);
            else if (dn && o.cur < 2 && (o.cur == 0 ? o.u2 : o.u3))
                n.cur = o.cur + 1;
            else if (up && o.cur > 0) n.cur = o.cur - 1;
        end else if (o.scr == 3 || o.scr == 5 || o.scr == 8) begin
            if (sel)
                nxt = (o.cur != 0) ? 0 : (o.scr == 8) ? 2 * o.stg : o.scr + 1;
            else if (dn) n.cur = 1;
            else if (up) n.cur = 0;
        end else if (o.scr == 7) begin
            if (sel) nxt = 1;
        end else if (o.scr == 1) begin
            if (sel) nxt = 0;
        end else begin
            nxt = 0;
        end
        if (nxt != o.scr) begin
            n.scr = nxt;
            n.cur = 0;
            n.age = 0;
            if (is_stage(nxt)) begin
                n.keys = 0;
                n.heart = START;
                n.hage = HOLD;
                n.todo = (nxt == 4) ? 2 : 1;
                n.stg = nxt / 2;
            end else begin
                n.todo = 0;
            end
        end else begin
            n.age = (o.age >= HOLD) ? HOLD : o.age + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m <= mreset();
        else
            m <= step(m, {btn_up, btn_down, btn_sel,
                          ev_key, ev_light, ev_door, ev_hit});
    end

    logic [16:0] act_v, exp_v;

    always @(negedge clk) begin
        act_v = {state, cursor, key_find, heart, todo, play_valid, busy};
        exp_v = {4'(m.scr), 2'(m.cur), 2'(m.keys), 2'(m.heart), 2'(m.todo),
                 m.u3, m.u2, 2'b10, (m.age < HOLD)};
        n_tot++;
        if (act_v === exp_v)
            n_pass++;
        else
            $display("FAIL cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic cyc(input logic [6:0] v);
        {btn_up, btn_down, btn_sel, ev_key, ev_light, ev_door, ev_hit} = v;
        @(negedge clk);
        {btn_up, btn_down, btn_sel, ev_key, ev_light, ev_door, ev_hit} = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        chk("rst_state", state, 0);
        chk("rst_pv", play_valid, 4'b0010);
        chk("rst_heart", heart, 0);
        chk("rst_busy", busy, 0);
        chk("rst_todo", todo, 0);
        rst_n = 1'b1;
        idle(2);
        chk("rel_busy", busy, 0);

        cyc(B_DN);
        chk("title_locked_dn", cursor, 0);
        cyc(B_SEL);
        chk("enter1_state", state, 2);
        chk("enter1_busy", busy, 1);
        chk("enter1_todo", todo, 1);
        chk("enter1_heart", heart, 3);
        idle(3);
        chk("busy_c4", busy, 1);
        idle(1);
        chk("busy_c5", busy, 0);

        cyc(E_KEY);
        chk("key1", key_find, 1);
        cyc(E_KEY);
        chk("key2", key_find, 2);
        cyc(E_KEY);
        chk("key3", key_find, 3);
        chk("todo_door", todo, 3);
        cyc(E_DOOR);
        chk("succ1_state", state, 3);
        chk("succ1_pv", play_valid, 4'b0110);

        idle(4);
        cyc(B_SEL);
        chk("st2_state", state, 4);
        chk("st2_todo", todo, 2);
        cyc(E_KEY);
        chk("st2_key_ign", key_find, 0);
        cyc(E_LIGHT);
        chk("st2_light", todo, 1);

        cyc(E_HIT);
        chk("hit1", heart, 2);
        cyc(E_HIT);
        chk("hit_invuln", heart, 2);
        idle(4);
        cyc(E_HIT);
        chk("hit2", heart, 1);
        idle(4);
        cyc(E_HIT | E_KEY);
        chk("hit3_heart", heart, 0);
        chk("hit3_state", state, 8);
        chk("hit3_key", key_find, 1);

        idle(4);
        cyc(B_DN);
        chk("fail_dn", cursor, 1);
        cyc(B_UP);
        chk("fail_up", cursor, 0);
        cyc(B_SEL);
        chk("retry_state", state, 4);
        chk("retry_heart", heart, 3);

        cyc(E_LIGHT);
        repeat (3) cyc(E_KEY);
        chk("st2_door_todo", todo, 3);
        cyc(E_DOOR | E_HIT);
        chk("door_hit_state", state, 5);
        chk("door_hit_heart", heart, 3);
        chk("succ2_pv", play_valid, 4'b1110);

        idle(4);
        cyc(B_DN);
        cyc(B_SEL);
        chk("succ2_title", state, 0);
        idle(4);
        cyc(B_DN);
        cyc(B_DN);
        cyc(B_DN);
        chk("title_sat", cursor, 2);
        cyc(B_UP);
        chk("title_up", cursor, 1);
        cyc(B_DN);
        cyc(B_SEL);
        chk("st3_state", state, 6);
        chk("st3_todo", todo, 1);

        repeat (3) cyc(E_KEY);
        cyc(E_DOOR);
        chk("succ3_state", state, 7);
        idle(4);
        cyc(B_SEL);
        chk("staff_state", state, 1);
        idle(4);
        cyc(B_SEL);
        chk("staff_title", state, 0);
        cyc(B_DN);
        chk("busy_btn_ign", cursor, 0);
        idle(4);
        cyc(B_DN);
        cyc(B_DN);
        cyc(B_SEL);
        cyc(E_KEY);
        chk("st3b_key", key_find, 1);
        chk("st3b_busy", busy, 1);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_pv", play_valid, 4'b0010);
        chk("arst_busy", busy, 0);
        chk("arst_heart", heart, 0);
        chk("arst_key", key_find, 0);
        chk("arst_todo", todo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, length of the screen-transition lock and of post-hit invulnerability, in clk cycles.
REQ-002 SHALL have parameter START_HEART, default 3, lives loaded on stage entry (range 1..3).
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports btn_up, btn_down, btn_sel, input, 1 each, single-cycle debounced press pulses.
REQ-006 SHALL have ports ev_key, ev_light, ev_door, ev_hit, input, 1 each, single-cycle gameplay pulses: key picked, light found, door touched, damage.
REQ-007 SHALL have port state, output, 4, screen code: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
REQ-008 SHALL have ports key_find (2), heart (2), todo (2; NONE=0, FIND_KEY=1, FIND_LIGHT=2, FIND_DOOR=3), play_valid (4), cursor (2), busy (1), all outputs.

Function
REQ-009 All outputs SHALL be registered; an accepted input pulse SHALL be reflected on outputs exactly one cycle later.
REQ-010 A 1-bit register SHALL record entry into a new state; on every state change the transition timer SHALL load HOLD_CYCLES-1, busy=1, and btn_* SHALL be ignored until the timer reaches 0 (busy=0 next cycle).
REQ-011 On every state change cursor SHALL reset to 0.
REQ-012 TITLE: cursor 0/1/2 = stage1/2/3; btn_down SHALL increment only if the target stage is unlocked (play_valid[cursor+2]), else hold; btn_up SHALL decrement, saturating at 0; btn_sel SHALL enter STAGE(cursor+1).
REQ-013 play_valid[0] SHALL be 0, play_valid[1] SHALL be 1 constantly; bits 2 and 3 SHALL be sticky until reset.
REQ-014 Stage entry (from TITLE, SUCCESS next, or FAIL retry) SHALL set key_find=0, heart=START_HEART, hit timer=0, todo=FIND_LIGHT for STAGE2 else FIND_KEY; a cur_stage register SHALL store 1..3.
REQ-015 In a stage, ev_light with todo==FIND_LIGHT SHALL set todo=FIND_KEY; ev_light otherwise ignored.
REQ-016 In a stage, ev_key with todo==FIND_KEY SHALL increment key_find; when key_find becomes 3, todo SHALL become FIND_DOOR in the same update; key_find SHALL never exceed 3.
REQ-017 ev_door with todo==FIND_DOOR SHALL go to SUCCESSk and set play_valid[k+1] for k=1,2; ev_door otherwise ignored.
REQ-018 ev_hit with hit timer==0 SHALL decrement heart and load hit timer HOLD_CYCLES-1; hits while hit timer>0 SHALL be ignored; hit timer SHALL decrement to 0 and hold.
REQ-019 ev_hit accepted with heart==1 SHALL go to FAIL with heart=0; heart SHALL never wrap below 0.
REQ-020 Simultaneous ev_door (accepted) and ev_hit: door SHALL win, heart unchanged; simultaneous ev_key and accepted ev_hit: both SHALL apply.
REQ-021 Gameplay events SHALL be processed during busy; btn_* in stage states SHALL have no effect.
REQ-022 SUCCESS1/2 and FAIL: cursor 0/1 toggled by btn_up/btn_down (saturating); btn_sel at 0 SHALL go to STAGE(k+1) (SUCCESS) or retry STAGE(cur_stage) (FAIL); at 1 SHALL go to TITLE.
REQ-023 SUCCESS3: btn_sel SHALL go to STAFF; STAFF: btn_sel SHALL go to TITLE; cursor held 0 in both.
REQ-024 Outside stage states todo SHALL be NONE; key_find and heart SHALL hold last values.
REQ-025 Unused state codes 9..15 SHALL go to TITLE on the next cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state=TITLE, cursor=0, key_find=0, heart=0, todo=NONE, play_valid=4'b0010, busy=0, both timers=0, cur_stage=1, including mid-stage or mid-lock.
REQ-027 Release of rst_n SHALL not start a transition lock.

Verification
REQ-028 Reset, btn_down then btn_sel (HOLD_CYCLES=4) -> cursor stays 0, state=2, busy=1 for 4 cycles, todo=1, heart=3.
REQ-029 STAGE1: 3x ev_key, ev_door -> key_find 1,2,3, todo=3, state=3, play_valid=4'b0110.
REQ-030 STAGE2 entry -> todo=2; ev_key ignored; ev_light -> todo=1.
REQ-031 Three ev_hit spaced > HOLD_CYCLES -> heart 2,1,0, state=8; two hits one cycle apart -> single decrement.
REQ-032 todo=3, ev_door and ev_hit same cycle -> state=SUCCESSk, heart unchanged; FAIL cursor 0 + btn_sel -> same stage, heart=3.
REQ-033 rst_n pulsed low in STAGE3 during busy -> all REQ-026 values within the reset cycle, play_valid=4'b0010.
